stream_parity_unit: RTL and testbench

Streaming parity generator/checker for multi-beat packets on a valid/ready interface. Accumulates parity across all beats of a packet of DATA_W-bit words and emits one result per packet: the generated parity bit, a mismatch flag against the expected parity, and the beat count. A saturating error counter supports link-health monitoring. Sits between a packet source and the framing/checking logic of the datapath.

---
 rtl/stream_parity_unit_pkg.sv | 18 +
 rtl/stream_parity_unit_if.sv | 26 ++
 rtl/stream_parity_unit_par_reduce.sv | 9 +
 rtl/stream_parity_unit.sv | 103 ++++++++++
 tb/tb_stream_parity_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/stream_parity_unit_pkg.sv
// Shared types and helpers for the streaming parity unit.
package stream_parity_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    // Increment that sticks at maxv; callers cast to their own width (<= 32 bits).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/stream_parity_unit_if.sv
// Beat stream in, packet result out; slave is the parity unit side.
interface stream_parity_unit_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_par;
    logic              out_valid;
    logic              out_ready;
    logic              out_par;
    logic              out_err;
    logic [CNT_W-1:0]  out_beats;

    modport slave (
        input  in_valid, in_data, in_last, in_par, out_ready,
        output in_ready, out_valid, out_par, out_err, out_beats
    );

    modport master (
        output in_valid, in_data, in_last, in_par, out_ready,
        input  in_ready, out_valid, out_par, out_err, out_beats
    );
endinterface

// File: rtl/stream_parity_unit_par_reduce.sv
// Combinational XOR reduction of one data beat.
module par_reduce #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    output logic              par
);
    assign par = ^data;
endmodule

// File: rtl/stream_parity_unit.sv
// Streaming packet parity generator/checker with saturating beat and error counters.
module stream_parity_unit
    import stream_parity_unit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int ERR_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 odd_mode,
    input  logic                 clr_err,
    stream_parity_unit_if.slave  s,
    output logic [ERR_W-1:0]     err_count
);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);

    state_t           state;
    logic             acc;
    logic             mode_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat_par;
    logic             accept;
    logic             handoff;

    par_reduce #(.DATA_W(DATA_W)) u_par_reduce (
        .data (s.in_data),
        .par  (beat_par)
    );

    // Ready follows rst_n directly so it drops the moment reset asserts.
    assign s.in_ready = rst_n && (state != HOLD);
    assign accept     = s.in_valid && s.in_ready;
    assign handoff    = s.out_valid && s.out_ready;
    assign cnt_inc    = CNT_W'(sat_inc(32'(cnt), CNT_MAX));

    // Packet FSM: accumulate beats, then hold the registered result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= 1'b0;
            mode_q      <= MODE_EVEN;
            cnt         <= '0;
            s.out_valid <= 1'b0;
            s.out_par   <= 1'b0;
            s.out_err   <= 1'b0;
            s.out_beats <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q <= odd_mode;
                        acc    <= beat_par;
                        cnt    <= CNT_W'(1);
                        if (s.in_last) begin
                            state       <= HOLD;
                            s.out_valid <= 1'b1;
                            s.out_par   <= beat_par ^ odd_mode;
                            s.out_err   <= beat_par ^ odd_mode ^ s.in_par;
                            s.out_beats <= CNT_W'(1);
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc ^ beat_par;
                        cnt <= cnt_inc;
                        if (s.in_last) begin
                            state       <= HOLD;
                            s.out_valid <= 1'b1;
                            s.out_par   <= acc ^ beat_par ^ mode_q;
                            s.out_err   <= acc ^ beat_par ^ mode_q ^ s.in_par;
                            s.out_beats <= cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    if (s.out_ready) begin
                        state       <= IDLE;
                        s.out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Error counter: counts erroring handoffs, clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= '0;
        end else if (handoff && s.out_err) begin
            err_count <= ERR_W'(sat_inc(32'(err_count), ERR_MAX));
        end
    end

endmodule

// File: tb/tb_stream_parity_unit.sv
// Directed scoreboard bench for stream_parity_unit (small counters to hit saturation).
module tb_stream_parity_unit;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int ERR_W  = 2;
    localparam int TMO    = 50;

    typedef struct packed {
        logic             par;
        logic             err;
        logic [CNT_W-1:0] beats;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             odd_mode = 1'b0;
    logic             clr_err = 1'b0;
    logic [ERR_W-1:0] err_count;

    res_t       sb [$];
    logic [7:0] pkt [$];
    int         checks = 0;
    int         errors = 0;
    int         err_model = 0;

    stream_parity_unit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) sif ();

    stream_parity_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .odd_mode  (odd_mode),
        .clr_err   (clr_err),
        .s         (sif),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive pkt[] as one packet; toggle_at flips odd_mode from that beat on.
    task automatic send_pkt(input logic mode, input logic par, input int toggle_at,
                            input int gap, input bit partial);
        logic x;
        int   n;
        int   w;
        res_t e;
        x = 1'b0;
        n = pkt.size();
        for (int i = 0; i < n; i++) x ^= ^pkt[i];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sif.in_valid = 1'b1;
            sif.in_data  = pkt[i];
            sif.in_last  = !partial && (i == n - 1);
            sif.in_par   = par;
            odd_mode     = (toggle_at >= 0 && i >= toggle_at) ? ~mode : mode;
            w = 0;
            while (!sif.in_ready && w < TMO) begin
                @(negedge clk);
                w++;
            end
            if (w >= TMO) chk("in_ready_timeout", 32'(sif.in_ready), 32'd1);
            @(posedge clk);
            #1;
            sif.in_valid = 1'b0;
            sif.in_last  = 1'b0;
            if (gap > 0 && i < n - 1) repeat (gap) @(negedge clk);
        end
        if (!partial) begin
            e.par   = x ^ mode;
            e.err   = x ^ mode ^ par;
            e.beats = (n > 3) ? CNT_W'(3) : CNT_W'(n);
            sb.push_back(e);
        end
    endtask

    // Expect the result one cycle after the last beat, optionally stall, then take it.
    task automatic recv(input int stall, input logic clr);
        res_t e;
        int   w;
        @(negedge clk);
        chk("latency", 32'(sif.out_valid), 32'd1);
        w = 0;
        while (!sif.out_valid && w < TMO) begin
            @(negedge clk);
            w++;
        end
        chk("sb_pending", 32'(sb.size()), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("out_par", 32'(sif.out_par), 32'(e.par));
        chk("out_err", 32'(sif.out_err), 32'(e.err));
        chk("out_beats", 32'(sif.out_beats), 32'(e.beats));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(sif.in_ready), 32'd0);
            chk("stall_valid", 32'(sif.out_valid), 32'd1);
            chk("stall_par", 32'(sif.out_par), 32'(e.par));
            chk("stall_beats", 32'(sif.out_beats), 32'(e.beats));
        end
        clr_err       = clr;
        sif.out_ready = 1'b1;
        @(posedge clk);
        if (clr) err_model = 0;
        else if (e.err && err_model < 3) err_model++;
        #1;
        sif.out_ready = 1'b0;
        clr_err       = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'(sif.out_valid), 32'd0);
        chk("post_in_ready", 32'(sif.in_ready), 32'd1);
        chk("err_count", 32'(err_count), 32'(err_model));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, 32'(sif.in_ready), 32'd0);
        chk({tag, "_valid"}, 32'(sif.out_valid), 32'd0);
        chk({tag, "_par"}, 32'(sif.out_par), 32'd0);
        chk({tag, "_err"}, 32'(sif.out_err), 32'd0);
        chk({tag, "_beats"}, 32'(sif.out_beats), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.in_last   = 1'b0;
        sif.in_par    = 1'b0;
        sif.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;
        #1 chk("release_in_ready", 32'(sif.in_ready), 32'd1);

        // Single beat, even: 0x07 has 3 ones -> par 1, matches in_par=1
        pkt = '{8'h07};
        send_pkt(1'b0, 1'b1, -1, 0, 1'b0);
        recv(0, 1'b0);

        // Odd mode, 11 ones -> par 0, in_par 1 mismatches
        pkt = '{8'h01, 8'h03, 8'hFF};
        send_pkt(1'b1, 1'b1, -1, 0, 1'b0);
        recv(0, 1'b0);

        // Backpressure for 5 cycles, with idle gaps between beats
        pkt = '{8'hA5, 8'h3C};
        send_pkt(1'b0, 1'b0, -1, 2, 1'b0);
        recv(5, 1'b0);

        // Mode toggled on beat 2 is ignored; 4 beats saturate to 3
        pkt = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(1'b0, 1'b0, 1, 0, 1'b0);
        recv(0, 1'b0);

        // 6 beats, 7 ones -> par 1 over all beats, beats saturated at 3, erroring
        pkt = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h21};
        send_pkt(1'b0, 1'b0, -1, 0, 1'b0);
        recv(0, 1'b0);

        // Three more erroring packets: error counter saturates at 3
        for (int k = 0; k < 3; k++) begin
            pkt = '{8'hFF};
            send_pkt(1'b0, 1'b1, -1, 0, 1'b0);
            recv(0, 1'b0);
        end

        // Clear coincides with an erroring handoff: clear wins
        pkt = '{8'h80};
        send_pkt(1'b0, 1'b0, -1, 0, 1'b0);
        recv(0, 1'b1);

        // Make err_count nonzero, then reset asynchronously mid-packet
        pkt = '{8'hFF};
        send_pkt(1'b0, 1'b1, -1, 0, 1'b0);
        recv(0, 1'b0);
        pkt = '{8'hFF, 8'h01};
        send_pkt(1'b0, 1'b0, -1, 0, 1'b1);
        #2 rst_n = 1'b0;
        #1 reset_checks("midpkt_reset");
        err_model = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while holding a result: result discarded
        pkt = '{8'hFF};
        send_pkt(1'b0, 1'b1, -1, 0, 1'b0);
        @(negedge clk);
        chk("hold_valid", 32'(sif.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 reset_checks("hold_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh packet after reset
        pkt = '{8'h00};
        send_pkt(1'b0, 1'b0, -1, 0, 1'b0);
        recv(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
